imem_loader: RTL
================

# imem_loader

Byte-stream program loader sitting directly upstream of `RISCVCore`'s instruction memory. It accepts a length-prefixed little-endian byte stream over a valid/ready handshake, assembles 32-bit instruction words, and writes them into consecutive instruction-memory words starting at word 0. It holds the core in reset until a complete program has been written, replacing hierarchical preloading of `instr_mem.memory` in benches and on hardware.

## Interface
- `ADDR_W`, 8: instruction-memory word-address width; capacity is 2^ADDR_W words.
- `clk` in 1: sole clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `start` in 1: single-cycle pulse that begins a load; honoured only in IDLE, DONE or ERR.
- `s_valid` in 1: stream byte valid.
- `s_data` in 8: stream byte.
- `s_ready` out 1: loader accepts a byte this cycle; a byte transfers when `s_valid & s_ready`.
- `mem_we` out 1: instruction-memory write strobe, one cycle per word.
- `mem_addr` out ADDR_W: word index being written.
- `mem_wdata` out 32: assembled instruction word.
- `core_rst` out 1: reset to `RISCVCore`; high except in DONE.
- `busy` out 1: high in LEN0, LEN1, DATA, CSUM.
- `done` out 1: high in DONE.
- `error` out 1: high in ERR.
- `words_loaded` out 16: count of words written in the current load.

## Operation
- Stream format: byte 0 is N[7:0] and byte 1 is N[15:8], where N is the word count. These are followed by 4·N data bytes, least-significant byte of each word first. A checksum byte follows when configured.
- States:
  - IDLE: `s_ready`=0. `start` → LEN0.
  - LEN0: `s_ready`=1. A byte latches N[7:0] → LEN1.
  - LEN1: `s_ready`=1. A byte latches N[15:8] and clears `words_loaded`, the byte counter and the checksum.
    - N > 2^ADDR_W → ERR.
    - N = 0 → CSUM if configured, else DONE.
    - Otherwise → DATA.
  - DATA: `s_ready`=1. Each byte shifts into lane `byte_cnt` (0..3).
    - On lane 3, issue the write of that word and increment `words_loaded`.
    - After word N-1 → CSUM or DONE.
  - CSUM: `s_ready`=1. The byte is compared against the running XOR of all data bytes. Match → DONE; mismatch → ERR.
  - DONE: `core_rst`=0, `s_ready`=0. `start` → LEN0.
  - ERR: `core_rst`=1, `s_ready`=0. `start` → LEN0.
- Length bytes are not included in the checksum.
- `start` while `busy` is ignored.
- Bytes presented while `s_ready`=0 are not consumed.
- `mem_addr` equals the value of `words_loaded` before the increment, truncated to ADDR_W bits. With N = 2^ADDR_W the final address is 2^ADDR_W−1; the address never wraps.
- An ERR exit leaves already-written words in memory; no rollback.

## Timing
- Reset values:
  - `core_rst`=1.
  - `s_ready`, `mem_we`, `busy`, `done`, `error` = 0.
  - `mem_addr`, `mem_wdata`, `words_loaded` = 0.
  - State = IDLE.
- All outputs are registered.
- `s_ready` reflects the current state, so a byte can transfer every cycle; there is no backpressure during memory writes.
- Write latency: `mem_we` is high for exactly one cycle, the cycle after the lane-3 handshake, with `mem_addr` and `mem_wdata` stable in that cycle.
- Entry into DONE occurs on the same edge that registers the final `mem_we`, so `core_rst` falls no earlier than the final write cycle. The memory captures the word on that same edge that the core leaves reset.
- `start` in DONE re-asserts `core_rst` one cycle later.
- `rst` mid-load: immediate return to IDLE, the partial word is discarded, and `core_rst`=1.
- Streaming throughput is 1 byte/cycle, so a word's write overlaps the next word's first byte.

## Configuration
- `IMEM_LOADER_CHECKSUM_EN` defined:
  - The CSUM state and the 8-bit XOR accumulator exist.
  - A trailing checksum byte is required.
  - Mismatch → ERR.
- Not defined:
  - No CSUM state and no checksum byte.
  - The last data byte (or LEN1 with N=0) goes directly to DONE.
  - ERR is reachable only via length overflow.

## Test plan
- Load N=5 with words 00500093, 00300113, 002081B3, 00302023, 00002203, streamed as bytes 05 00 93 00 50 00 … → five `mem_we` pulses at addresses 0–4 with exactly those words, `done`=1, `core_rst` falls, and `words_loaded`=5.
- Same program with checksum enabled:
  - Correct XOR byte → DONE.
  - Flipped byte → `error`=1, `core_rst` stays 1, `done`=0.
- N=257 with ADDR_W=8: the LEN1 byte `01` following `01` → ERR immediately, and no `mem_we` ever occurs.
- N=0: stream 00 00 (plus checksum 00 if enabled) → DONE with no writes and `words_loaded`=0.
- Stall and backpressure:
  - `s_valid` toggled randomly mid-word → identical memory contents.
  - `start` pulsed while busy → ignored.
- Assert `rst` after 6 data bytes, then reload → the first load's partial word is never written and the second load completes correctly from address 0.

Source files
------------

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - length-prefixed byte-stream loader for RISCVCore instruction memory
// Optional trailing XOR checksum byte: define IMEM_LOADER_CHECKSUM_EN.
module imem_loader #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              s_valid,
  input  logic [7:0]        s_data,
  output logic              s_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              core_rst,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [15:0]       words_loaded
);

`ifdef IMEM_LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {S_IDLE, S_LEN0, S_LEN1, S_DATA, S_CSUM, S_DONE, S_ERR} state_t;
  localparam state_t S_FINISH = S_CSUM;
`else
  typedef enum logic [2:0] {S_IDLE, S_LEN0, S_LEN1, S_DATA, S_DONE, S_ERR} state_t;
  localparam state_t S_FINISH = S_DONE;
`endif

  localparam logic [16:0] CAP = 17'(1) << ADDR_W;

  state_t              state_q, state_d;
  logic [15:0]         len_q, len_d;
  logic [1:0]          byte_cnt_q, byte_cnt_d;
  logic [23:0]         lanes_q, lanes_d;
  logic [15:0]         words_q, words_d;
  logic                mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [31:0]         mem_wdata_q, mem_wdata_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                error_q, error_d;
  logic                core_rst_q, core_rst_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]          csum_q, csum_d;
`endif
  logic                xfer;

  // s_ready is the registered "busy" flag: every busy state accepts bytes
  assign xfer = s_valid & busy_q;

  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    byte_cnt_d  = byte_cnt_q;
    lanes_d     = lanes_q;
    words_d     = words_q;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
    csum_d      = csum_q;
`endif
    case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) state_d = S_LEN0;
      end
      S_LEN0: begin
        if (xfer) begin
          len_d[7:0] = s_data;
          state_d    = S_LEN1;
        end
      end
      S_LEN1: begin
        if (xfer) begin
          len_d[15:8] = s_data;
          words_d     = 16'd0;
          byte_cnt_d  = 2'd0;
`ifdef IMEM_LOADER_CHECKSUM_EN
          csum_d      = 8'd0;
`endif
          if ({1'b0, s_data, len_q[7:0]} > CAP) state_d = S_ERR;
          else if ({s_data, len_q[7:0]} == 16'd0) state_d = S_FINISH;
          else state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (xfer) begin
          byte_cnt_d = byte_cnt_q + 2'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
          csum_d     = csum_q ^ s_data;
`endif
          case (byte_cnt_q)
            2'd0: lanes_d[7:0]   = s_data;
            2'd1: lanes_d[15:8]  = s_data;
            2'd2: lanes_d[23:16] = s_data;
            default: begin
              // Final word and DONE land on the same edge so the core leaves reset with the write
              mem_we_d    = 1'b1;
              mem_addr_d  = words_q[ADDR_W-1:0];
              mem_wdata_d = {s_data, lanes_q};
              words_d     = words_q + 16'd1;
              if (words_d == len_q) state_d = S_FINISH;
            end
          endcase
        end
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      S_CSUM: begin
        if (xfer) state_d = (s_data == csum_q) ? S_DONE : S_ERR;
      end
`endif
      default: state_d = S_IDLE;
    endcase

`ifdef IMEM_LOADER_CHECKSUM_EN
    busy_d = (state_d == S_LEN0) || (state_d == S_LEN1) || (state_d == S_DATA) || (state_d == S_CSUM);
`else
    busy_d = (state_d == S_LEN0) || (state_d == S_LEN1) || (state_d == S_DATA);
`endif
    done_d     = (state_d == S_DONE);
    error_d    = (state_d == S_ERR);
    core_rst_d = (state_d != S_DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      len_q       <= 16'd0;
      byte_cnt_q  <= 2'd0;
      lanes_q     <= 24'd0;
      words_q     <= 16'd0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= 32'd0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
      core_rst_q  <= 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum_q      <= 8'd0;
`endif
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      byte_cnt_q  <= byte_cnt_d;
      lanes_q     <= lanes_d;
      words_q     <= words_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      error_q     <= error_d;
      core_rst_q  <= core_rst_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum_q      <= csum_d;
`endif
    end
  end

  assign s_ready      = busy_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign error        = error_q;
  assign core_rst     = core_rst_q;
  assign mem_we       = mem_we_q;
  assign mem_addr     = mem_addr_q;
  assign mem_wdata    = mem_wdata_q;
  assign words_loaded = words_q;

endmodule
